// File: rtl/cache_mem_pkg.sv
// rtl/cache_mem_pkg.sv - shared types, sizes and init pattern for the cache backing store
package cache_mem_pkg;

    localparam int MEM_WORDS  = 32;
    localparam int MEM_ADDR_W = 5;
    localparam int MEM_DATA_W = 16;

    typedef enum logic [3:0] {
        ST_INIT = 4'b0001,
        ST_IDLE = 4'b0010,
        ST_BUSY = 4'b0100,
        ST_DONE = 4'b1000
    } mem_state_t;

    // Power-on contents: high byte is the complement of the zero-extended index
    function automatic logic [MEM_DATA_W-1:0] init_word(input logic [MEM_ADDR_W-1:0] idx);
        logic [7:0] i8;
        i8 = {3'b000, idx};
        return {~i8, i8};
    endfunction

endpackage

// File: rtl/cache_mem_array.sv
// rtl/cache_mem_array.sv - 32x16 storage with synchronous write and registered, holding read
module cache_mem_array
    import cache_mem_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_we,
    input  logic [MEM_ADDR_W-1:0] i_waddr,
    input  logic [MEM_DATA_W-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [MEM_ADDR_W-1:0] i_raddr,
    output logic [MEM_DATA_W-1:0] o_rdata
);

    logic [MEM_DATA_W-1:0] r_mem [MEM_WORDS];
    logic [MEM_DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    // Read data only moves on an explicit read, so it holds across writes and idle time
    always_ff @(posedge clk) begin
        if (reset)
            r_rdata <= '0;
        else if (i_re)
            r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/cache_mem_responder.sv
// rtl/cache_mem_responder.sv - latency-programmable backing store for cache block transfers; MEM_STATS_EN adds rd/wr counters
module cache_mem_responder
    import cache_mem_pkg::*;
#(
    parameter int LATENCY = 4,
    parameter int CNT_W   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_rd,
    input  logic                  mem_wr,
    input  logic [MEM_ADDR_W-1:0] mem_addr,
    input  logic [MEM_DATA_W-1:0] mem_din,
    output logic [MEM_DATA_W-1:0] mem_dout,
    output logic                  mem_done,
    output logic                  mem_ready,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count,
    output logic                  proto_err
);

    localparam logic [CNT_W-1:0] LOAD = CNT_W'(LATENCY - 1);

    mem_state_t            r_state;
    logic [MEM_ADDR_W-1:0] r_init_idx;
    logic [CNT_W-1:0]      r_cnt;
    logic [MEM_ADDR_W-1:0] r_addr;
    logic [MEM_DATA_W-1:0] r_din;
    logic                  r_is_wr;
    logic                  r_done;
    logic                  r_proto_err;

    logic                  w_access;
    logic                  w_we;
    logic                  w_re;
    logic [MEM_ADDR_W-1:0] w_waddr;
    logic [MEM_DATA_W-1:0] w_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_INIT;
            r_init_idx  <= '0;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_din       <= '0;
            r_is_wr     <= 1'b0;
            r_done      <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_INIT: begin
                    r_init_idx <= r_init_idx + 1'b1;
                    if (r_init_idx == MEM_ADDR_W'(MEM_WORDS - 1))
                        r_state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (mem_rd || mem_wr) begin
                        r_addr  <= mem_addr;
                        r_din   <= mem_din;
                        r_is_wr <= mem_wr;
                        r_cnt   <= LOAD;
                        if (mem_rd && mem_wr)
                            r_proto_err <= 1'b1;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE:  r_state <= ST_IDLE;
                default:  r_state <= ST_INIT;
            endcase
        end
    end

    // The array access happens on the same edge that raises mem_done
    assign w_access = (r_state == ST_BUSY) && (r_cnt == '0);
    assign w_we     = (r_state == ST_INIT) || (w_access && r_is_wr);
    assign w_re     = w_access && !r_is_wr;
    assign w_waddr  = (r_state == ST_INIT) ? r_init_idx : r_addr;
    assign w_wdata  = (r_state == ST_INIT) ? init_word(r_init_idx) : r_din;

    cache_mem_array u_array (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_re    (w_re),
        .i_raddr (r_addr),
        .o_rdata (mem_dout)
    );

`ifdef MEM_STATS_EN
    logic [15:0] r_rd_count;
    logic [15:0] r_wr_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else if (w_access) begin
            if (r_is_wr && r_wr_count != 16'hFFFF)
                r_wr_count <= r_wr_count + 16'd1;
            if (!r_is_wr && r_rd_count != 16'hFFFF)
                r_rd_count <= r_rd_count + 16'd1;
        end
    end

    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;
`else
    assign rd_count = 16'h0000;
    assign wr_count = 16'h0000;
`endif

    assign mem_done  = r_done;
    assign mem_ready = (r_state == ST_IDLE);
    assign proto_err = r_proto_err;

endmodule

// File: tb/tb_cache_mem_responder.sv
// tb/tb_cache_mem_responder.sv - directed self-checking bench for cache_mem_responder (LATENCY 4 and 1)
module tb_cache_mem_responder;

`ifdef MEM_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_rd, mem_wr;
    logic [4:0]  mem_addr;
    logic [15:0] mem_din;
    logic [15:0] mem_dout;
    logic        mem_done, mem_ready, proto_err;
    logic [15:0] rd_count, wr_count;

    logic        rd1, wr1;
    logic [4:0]  addr1;
    logic [15:0] din1;
    logic [15:0] dout1;
    logic        done1, ready1, perr1;
    logic [15:0] rdc1, wrc1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cache_mem_responder #(.LATENCY(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_done(mem_done), .mem_ready(mem_ready), .rd_count(rd_count),
        .wr_count(wr_count), .proto_err(proto_err)
    );

    cache_mem_responder #(.LATENCY(1), .CNT_W(4)) dut_lat1 (
        .clk(clk), .reset(reset), .mem_rd(rd1), .mem_wr(wr1),
        .mem_addr(addr1), .mem_din(din1), .mem_dout(dout1),
        .mem_done(done1), .mem_ready(ready1), .rd_count(rdc1),
        .wr_count(wrc1), .proto_err(perr1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!mem_done && n < 64);
    endtask

    task automatic xfer(input logic r, input logic w, input logic [4:0] a,
                        input logic [15:0] d, input string tag);
        int n;
        mem_rd = r; mem_wr = w; mem_addr = a; mem_din = d;
        wait_done(n);
        check({tag, "_lat"}, n, 5);
        mem_rd = 1'b0; mem_wr = 1'b0;
        tick();
        check({tag, "_pulse"}, mem_done, 0);
    endtask

    initial begin
        int n, dones;
        reset = 1'b1;
        mem_rd = 1'b1; mem_wr = 1'b0; mem_addr = 5'd5; mem_din = 16'h0;
        rd1 = 1'b0; wr1 = 1'b0; addr1 = 5'd0; din1 = 16'h0;
        tick(); tick();
        check("rst_done", mem_done, 0);
        check("rst_dout", mem_dout, 16'h0000);
        check("rst_perr", proto_err, 0);
        check("rst_ready", mem_ready, 0);
        check("rst_rdc", rd_count, 0);
        reset = 1'b0;

        n = 0;
        while (!mem_ready && n < 100) begin
            tick();
            n++;
        end
        check("init_cycles", n, 32);

        wait_done(n);
        check("rd5_lat", n, 5);
        check("rd5_data", mem_dout, 16'hFA05);
        mem_rd = 1'b0;
        tick();
        check("rd5_pulse", mem_done, 0);
        check("rd5_rdc", rd_count, STATS ? 32'd1 : 32'd0);

        xfer(1'b0, 1'b1, 5'd3, 16'hBEEF, "wr3");
        check("wr3_dout_hold", mem_dout, 16'hFA05);
        check("wr3_wrc", wr_count, STATS ? 32'd1 : 32'd0);
        xfer(1'b1, 1'b0, 5'd3, 16'h0, "rd3");
        check("rd3_data", mem_dout, 16'hBEEF);

        mem_wr = 1'b1; mem_addr = 5'd7; mem_din = 16'h1234;
        wait_done(n);
        check("ff_wr_lat", n, 5);
        mem_wr = 1'b0; mem_rd = 1'b1; mem_addr = 5'd12;
        wait_done(n);
        check("ff_rd_lat", n, 6);
        check("ff_rd_data", mem_dout, 16'hF30C);
        mem_rd = 1'b0;
        tick();
        check("ff_pulse", mem_done, 0);
        xfer(1'b1, 1'b0, 5'd7, 16'h0, "rd7");
        check("rd7_data", mem_dout, 16'h1234);
        check("perr_clean", proto_err, 0);

        xfer(1'b1, 1'b1, 5'd2, 16'h00AA, "both2");
        check("perr_set", proto_err, 1);
        check("both2_dout_hold", mem_dout, 16'h1234);
        xfer(1'b1, 1'b0, 5'd2, 16'h0, "rd2");
        check("rd2_data", mem_dout, 16'h00AA);
        check("perr_sticky", proto_err, 1);
        check("tot_rdc", rd_count, STATS ? 32'd5 : 32'd0);
        check("tot_wrc", wr_count, STATS ? 32'd3 : 32'd0);

        mem_wr = 1'b1; mem_addr = 5'd4; mem_din = 16'hDEAD;
        tick(); tick(); tick();
        check("busy_no_done", mem_done, 0);
        reset = 1'b1; mem_wr = 1'b0;
        tick();
        check("mid_rst_done", mem_done, 0);
        check("mid_rst_perr", proto_err, 0);
        check("mid_rst_dout", mem_dout, 16'h0000);
        check("mid_rst_rdc", rd_count, 0);
        check("mid_rst_wrc", wr_count, 0);
        reset = 1'b0;
        n = 0; dones = 0;
        while (!mem_ready && n < 100) begin
            tick();
            n++;
            dones += int'(mem_done);
        end
        check("init2_cycles", n, 32);
        check("init2_spurious_done", dones, 0);
        check("lat1_ready", ready1, 1);

        rd1 = 1'b1; addr1 = 5'd31;
        n = 0;
        do begin
            tick();
            n++;
        end while (!done1 && n < 16);
        check("lat1_lat", n, 2);
        check("lat1_data", dout1, 16'hE01F);
        rd1 = 1'b0;
        tick();
        check("lat1_pulse", done1, 0);
        check("lat1_rdc", rdc1, STATS ? 32'd1 : 32'd0);

        xfer(1'b1, 1'b0, 5'd4, 16'h0, "rd4");
        check("rd4_data", mem_dout, 16'hFB04);
        check("rd4_rdc", rd_count, STATS ? 32'd1 : 32'd0);
        check("rd4_wrc", wr_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
